// File: rtl/oneshot_pkg.sv
// Oneshot counter shared types.
// Default sizes and the step decode.
package oneshot_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_SYNC  = 2;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DN   = 2'b10
  } step_e;

  // Both pulses together cancel out.
  function automatic step_e step_of(
    input logic up,
    input logic dn
  );
    step_e s;
    s = STEP_HOLD;
    if (up && !dn) s = STEP_UP;
    if (dn && !up) s = STEP_DN;
    return s;
  endfunction

endpackage

// File: rtl/oneshot_if.sv
// Oneshot level inputs and count output.
// Bundled for benches and wrappers.
interface oneshot_if #(
  parameter int WIDTH = 4
);

  logic             ln0;
  logic             ln1;
  logic [WIDTH-1:0] dataout;

  modport master (
    output ln0,
    output ln1,
    input  dataout
  );

  modport slave (
    input  ln0,
    input  ln1,
    output dataout
  );

endinterface

// File: rtl/oneshot_edge.sv
// Input synchronizer plus rising-edge
// one-shot detector.
module oneshot_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  localparam int NS =
    (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] sync;
  logic          hist;

  // Shift the async level into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[NS-2:0], din};
    end
  end

  // Remember last synchronized level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= 1'b0;
    end else begin
      hist <= sync[NS-1];
    end
  end

  assign pulse = sync[NS-1] & ~hist;

endmodule

// File: rtl/oneshot.sv
// Up/down counter driven by two
// debounced-edge one-shot inputs.
module oneshot
  import oneshot_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ln0,
  input  logic             ln1,
  output logic [WIDTH-1:0] dataout
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic  up;
  logic  dn;
  step_e step;

  oneshot_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_up (
    .clk  (clk),
    .reset(reset),
    .din  (ln0),
    .pulse(up)
  );

  oneshot_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dn (
    .clk  (clk),
    .reset(reset),
    .din  (ln1),
    .pulse(dn)
  );

  assign step = step_of(up, dn);

  // Count modulo 2^WIDTH on each step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataout <= '0;
    end else begin
      unique case (step)
        STEP_UP: dataout <= dataout + ONE;
        STEP_DN: dataout <= dataout - ONE;
        default: dataout <= dataout;
      endcase
    end
  end

endmodule

// File: tb/tb_oneshot.sv
// Scoreboard bench for oneshot.
// Stimulus pushes expected counts.
module tb_oneshot;

  typedef struct {
    logic [3:0] val;
    int         cyc;
    bit         any;
  } exp_t;

  logic clk;
  logic reset;
  oneshot_if #(.WIDTH(4)) bus ();

  exp_t       q[$];
  int         checks;
  int         passes;
  int         cyc;
  int         model;
  bit         free_run;
  logic [3:0] prev;

  oneshot #(
    .WIDTH      (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ln0    (bus.ln0),
    .ln1    (bus.ln1),
    .dataout(bus.dataout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d want %0d", name, act, req);
  endtask

  // Monitor: every change of dataout must match the queue head.
  always @(negedge clk) begin
    if (bus.dataout !== prev) begin
      if (!free_run) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change: got %0d at cycle %0d want no change",
                   bus.dataout, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.val !== bus.dataout)
            $display("FAIL count_value: got %0d want %0d", bus.dataout, e.val);
          else if (!e.any && e.cyc != cyc)
            $display("FAIL latency: got cycle %0d want cycle %0d", cyc, e.cyc);
          else passes++;
        end
      end
      prev = bus.dataout;
    end
  end

  task automatic mid();
    @(posedge clk);
    #3;
  endtask

  task automatic push(int v, int c, bit any);
    exp_t e;
    e.val = v[3:0];
    e.cyc = c;
    e.any = any;
    q.push_back(e);
  endtask

  // Press ln0/ln1 mid-cycle, hold hi cycles, release, idle lo cycles.
  task automatic press(bit a, bit b, int hi, int lo);
    mid();
    if (a != b) begin
      model = a ? (model + 1) % 16 : (model + 15) % 16;
      push(model, cyc + 3, 1'b0);
    end
    bus.ln0 = a;
    bus.ln1 = b;
    repeat (hi) @(posedge clk);
    #3;
    bus.ln0 = 1'b0;
    bus.ln1 = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  // Async reset between edges; dataout must clear at once.
  task automatic pulse_reset(int cycles);
    mid();
    if (model != 0) push(0, 0, 1'b1);
    model = 0;
    reset = 1'b0;
    #1;
    check("reset_immediate", bus.dataout, 4'd0);
    repeat (cycles) @(posedge clk);
    #2;
    check("reset_hold", bus.dataout, 4'd0);
    mid();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int r1;
    checks   = 0;
    passes   = 0;
    cyc      = 0;
    model    = 0;
    free_run = 1'b0;
    prev     = 4'd0;
    r0       = 0;
    r1       = 0;
    bus.ln0  = 1'b0;
    bus.ln1  = 1'b0;
    reset    = 1'b0;

    #100;
    check("reset_state", bus.dataout, 4'd0);
    #3;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    check("idle_after_reset", bus.dataout, 4'd0);

    press(1'b1, 1'b0, 10, 4);
    check("held_once", bus.dataout, 4'd1);

    repeat (8) press(1'b1, 1'b0, 4, 4);
    check("count_nine", bus.dataout, 4'd9);
    pulse_reset(3);
    repeat (4) @(posedge clk);

    repeat (16) press(1'b1, 1'b0, 4, 4);
    check("wrap_up", bus.dataout, 4'd0);

    press(1'b0, 1'b1, 4, 4);
    check("wrap_down", bus.dataout, 4'd15);
    press(1'b0, 1'b1, 4, 4);
    check("dec_14", bus.dataout, 4'd14);

    repeat (7) press(1'b1, 1'b0, 2, 3);
    check("count_five", bus.dataout, 4'd5);
    press(1'b1, 1'b1, 5, 5);
    check("both_cancel", bus.dataout, 4'd5);

    mid();
    free_run = 1'b1;
    fork
      begin
        repeat (20) begin
          #50;
          bus.ln0 = ~bus.ln0;
          if (bus.ln0) r0++;
        end
      end
      begin
        repeat (8) begin
          #135;
          bus.ln1 = ~bus.ln1;
          if (bus.ln1) r1++;
        end
      end
    join
    repeat (6) @(posedge clk);
    #3;
    free_run = 1'b0;
    model = (((model + r0 - r1) % 16) + 16) % 16;
    check("toggle_net", bus.dataout, model[3:0]);

    mid();
    model = (model + 1) % 16;
    push(model, cyc + 3, 1'b0);
    bus.ln0 = 1'b1;
    repeat (8) @(posedge clk);
    pulse_reset(2);
    model = 1;
    push(1, cyc + 3, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    check("high_at_release", bus.dataout, 4'd1);
    bus.ln0 = 1'b0;
    repeat (6) @(posedge clk);
    #3;

    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL queue_drain: got %0d pending want 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
